serial_pattern_source: RTL and testbench
========================================

# serial_pattern_source

Upstream stimulus stage for the sequence detector: captures a bit pattern of programmable length and replays it MSB-first as a serial stream. Output `w_out` drives the detector's `w` input, and `w_valid` gates the detector's state advance. Bit rate is set by a programmable cycle divider, so the detector can be exercised hands-free on board or in simulation instead of from a toggled switch.

## Interface
- `DATA_W`, default 8: maximum pattern length in bits.
- `LEN_W`, default 4: width of `len` and `bits_left`; must hold `DATA_W`.
- `RATE_W`, default 8: width of the `rate` divider input.

Ports:
- `clock`, in, 1: rising-edge clock.
- `resetn`, in, 1: reset, synchronous, active-low.
- `load`, in, 1: capture `pattern` and `len`.
- `pattern`, in, `DATA_W`: pattern bits. The active field is `pattern[len-1:0]`; bit `len-1` is sent first.
- `len`, in, `LEN_W`: number of bits to send.
- `rate`, in, `RATE_W`: clock cycles per bit, minus 1.
- `start`, in, 1: begin playback of the stored pattern.
- `w_out`, out, 1: current serial bit.
- `w_valid`, out, 1: one-cycle strobe; the consumer samples `w_out` in this cycle.
- `busy`, out, 1: high while shifting.
- `done`, out, 1: one-cycle pulse after the last bit.
- `bits_left`, out, `LEN_W`: bits not yet strobed, including the current bit.
- `repeat_mode`, in, 1: present only with the macro (see Configuration).

## Operation
The block is a state machine with states IDLE, READY, SHIFT and DONE.

- **Reset:** state IDLE; stored pattern, stored length, shift register, divider counter and `bits_left` are 0; all outputs are 0.
- **IDLE**
  - `load` with `len` ≠ 0: store `pattern`, store min(`len`, `DATA_W`), go to READY.
  - `load` with `len` = 0: ignored.
  - `start`: ignored.
- **READY**
  - `load`: re-captures under the same rules as IDLE and stays in READY. `load` has priority over `start` in the same cycle, and that `start` is dropped.
  - `start`: sample `rate` into the divider counter, copy the stored pattern into the shift register, set `bits_left` = stored length, go to SHIFT.
- **SHIFT**
  - `busy` = 1; `w_out` = shift register bit (`bits_left` − 1).
  - Divider counter decrements by 1 each cycle.
  - `w_valid` = (counter == 0), combinational from state and counter.
  - On a `w_valid` cycle: counter reloads the sampled rate, and `bits_left` decrements.
  - If `bits_left` was 1 on that `w_valid` cycle, go to DONE.
  - `load` and `start` are ignored. A change on `rate` has no effect until the next `start`.
- **DONE:** lasts exactly one cycle with `done` = 1, then goes to READY. The stored pattern is retained, so a later `start` replays it.
- **Outputs outside SHIFT:** `w_out`, `w_valid` and `busy` are 0 in IDLE, READY and DONE. `bits_left` is 0 outside SHIFT.

## Timing
- All state changes occur on the rising edge of `clock`. `load` and `start` are level-sampled at that edge; a request held high is seen on every edge.
- **Start latency:** `start` sampled at edge k makes SHIFT active from cycle k+1.
- **Strobe timing:** the first `w_valid` falls in SHIFT cycle `rate`+1. Strobes repeat every `rate`+1 cycles, and `w_out` is stable for `rate`+1 cycles around each strobe.
- **Duration:** SHIFT lasts `len`×(`rate`+1) cycles, and `done` is high in the cycle immediately after the last `w_valid`.
- **Minimum rate:** `rate` = 0 gives `w_valid` = 1 on every SHIFT cycle.
- **Maximum rate:** the all-ones `rate` gives 2^`RATE_W` cycles per bit. The divider does not wrap past 0.
- **Reset mid-operation:** `resetn` low at any edge forces IDLE on that edge, clears the stored pattern, and drops all outputs to 0. No `done` pulse is issued.

## Configuration
- **`SERIAL_SRC_REPEAT_EN` defined:** input `repeat_mode` exists.
  - If `repeat_mode` = 1 on the final-bit `w_valid` cycle, the block does not enter DONE. Instead it reloads the shift register from the stored pattern, sets `bits_left` = stored length, reloads the divider, and stays in SHIFT. Playback is gap-free, so the next bit is strobed `rate`+1 cycles later, and no `done` is issued.
  - If `repeat_mode` = 0 on that cycle, behaviour is single-shot as described above.
- **Not defined:** the port is absent and the block is single-shot only.

## Test plan
- **Single-shot, back-to-back strobes:** reset; load `pattern`=8'hB6, `len`=8; `rate`=0; start. Required: 8 consecutive `w_valid` cycles with `w_out` = 1,0,1,1,0,1,1,0; `done` in cycle 9 after start; then READY with `busy`=0.
- **Divider and short pattern:** load `pattern`=8'h0D, `len`=4; `rate`=2; start. Required: `w_valid` in SHIFT cycles 3, 6, 9, 12 carrying 1,1,0,1; `bits_left` steps 4→3→2→1; `done` at SHIFT cycle 13.
- **Ignored requests:** `load` with `len`=0 in IDLE leaves the state at IDLE. `load` during SHIFT does not disturb the stream. `load`+`start` together in READY captures only, with `busy` staying 0.
- **Reset mid-shift:** assert `resetn`=0 for one edge during the third bit. Required: next cycle IDLE, all outputs 0, no `done`, and `start` is ignored afterwards until a new `load`.
- **Length clamp and replay:** `len`=12 with `DATA_W`=8 sends exactly 8 bits. A second `start` after `done` replays the identical sequence.
- **With `SERIAL_SRC_REPEAT_EN` and `repeat_mode`=1:** `pattern`=4'hB, `len`=4, `rate`=0. Required: stream 1,0,1,1,1,0,1,1,… with `w_valid` continuously high and no `done`. Dropping `repeat_mode` ends the stream after the current pass, followed by `done`.

Source files
------------

// File: rtl/serial_pattern_source.sv
// Serial pattern source: captures a pattern of programmable length and replays it MSB-first at a divided bit rate.
// Defining SERIAL_SRC_REPEAT_EN adds the repeat_mode input for gap-free looping playback.
module serial_pattern_source #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4,
   parameter int RATE_W = 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              load,
   input  logic [DATA_W-1:0] pattern,
   input  logic [LEN_W-1:0]  len,
   input  logic [RATE_W-1:0] rate,
   input  logic              start,
   output logic              w_out,
   output logic              w_valid,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  bits_left
`ifdef SERIAL_SRC_REPEAT_EN
   ,
   input  logic              repeat_mode
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      READY,
      SHIFT,
      DONE
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [DATA_W-1:0] r_pattern;
   logic [LEN_W-1:0]  r_len;
   logic [DATA_W-1:0] r_shift;
   logic [RATE_W-1:0] r_count;
   logic [RATE_W-1:0] r_rate;
   logic [LEN_W-1:0]  r_bitsLeft;

   logic              w_repeat;
   logic              w_loadOk;
   logic              w_startOk;
   logic [LEN_W-1:0]  w_lenClamped;
   logic              w_strobe;
   logic              w_lastBit;
   logic [DATA_W-1:0] w_alignedPattern;

`ifdef SERIAL_SRC_REPEAT_EN
   assign w_repeat = repeat_mode;
`else
   assign w_repeat = 1'b0;
`endif

   assign w_loadOk     = load && (len != '0);
   assign w_lenClamped = (len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len;
   // Any load in READY wins over a simultaneous start, which is then dropped.
   assign w_startOk    = (r_state == READY) && !load && start;
   assign w_strobe     = (r_state == SHIFT) && (r_count == '0);
   assign w_lastBit    = w_strobe && (r_bitsLeft == LEN_W'(1));

   // Left-align the active field so the first bit to send always sits in the MSB.
   assign w_alignedPattern = r_pattern << (LEN_W'(DATA_W) - r_len);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_loadOk) begin
               w_nextState = READY;
            end
         end
         READY: begin
            if (w_startOk) begin
               w_nextState = SHIFT;
            end
         end
         SHIFT: begin
            if (w_lastBit && !w_repeat) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = READY;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // The divider counts down to zero and reloads the rate sampled at start, so a bit lasts rate+1 cycles.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_pattern  <= '0;
         r_len      <= '0;
         r_shift    <= '0;
         r_count    <= '0;
         r_rate     <= '0;
         r_bitsLeft <= '0;
      end else begin
         if (w_loadOk && ((r_state == IDLE) || (r_state == READY))) begin
            r_pattern <= pattern;
            r_len     <= w_lenClamped;
         end
         if (w_startOk) begin
            r_count    <= rate;
            r_rate     <= rate;
            r_shift    <= w_alignedPattern;
            r_bitsLeft <= r_len;
         end
         if (r_state == SHIFT) begin
            if (w_strobe) begin
               r_count <= r_rate;
               if (w_lastBit) begin
                  if (w_repeat) begin
                     r_shift    <= w_alignedPattern;
                     r_bitsLeft <= r_len;
                  end else begin
                     r_shift    <= '0;
                     r_bitsLeft <= '0;
                  end
               end else begin
                  r_shift    <= r_shift << 1;
                  r_bitsLeft <= r_bitsLeft - LEN_W'(1);
               end
            end else begin
               r_count <= r_count - RATE_W'(1);
            end
         end
      end
   end

   always_comb begin
      w_out     = 1'b0;
      w_valid   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      bits_left = '0;
      case (r_state)
         SHIFT: begin
            busy      = 1'b1;
            w_out     = r_shift[DATA_W-1];
            w_valid   = (r_count == '0);
            bits_left = r_bitsLeft;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_pattern_source.sv
// Directed testbench for serial_pattern_source; the repeat scenario is compiled in only with SERIAL_SRC_REPEAT_EN.
module tb_serial_pattern_source;

   logic       clock;
   logic       resetn;
   logic       load;
   logic [7:0] pattern;
   logic [3:0] len;
   logic [7:0] rate;
   logic       start;
   logic       w_out;
   logic       w_valid;
   logic       busy;
   logic       done;
   logic [3:0] bits_left;
`ifdef SERIAL_SRC_REPEAT_EN
   logic       repeat_mode;
`endif

   int assertCount;
   int failCount;

   serial_pattern_source #(
      .DATA_W(8),
      .LEN_W (4),
      .RATE_W(8)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .load       (load),
      .pattern    (pattern),
      .len        (len),
      .rate       (rate),
      .start      (start),
      .w_out      (w_out),
      .w_valid    (w_valid),
      .busy       (busy),
      .done       (done),
      .bits_left  (bits_left)
`ifdef SERIAL_SRC_REPEAT_EN
      ,
      .repeat_mode(repeat_mode)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle, so inputs are driven and outputs sampled away from the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      resetn = 1'b0;
      step();
      step();
      resetn = 1'b1;
   endtask

   task automatic doLoad(input logic [7:0] p, input logic [3:0] l);
      pattern = p;
      len     = l;
      load    = 1'b1;
      step();
      load    = 1'b0;
   endtask

   task automatic doStart(input logic [7:0] r);
      rate  = r;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      assertCount++;
      if ({w_out, w_valid, busy, done, bits_left} !== 8'h00) begin
         failCount++;
         $display("[TB] FAIL reset_outputs: got %b, expected 00000000", {w_out, w_valid, busy, done, bits_left});
      end
   endtask

   task automatic test_single_shot();
      logic [7:0] expBits;
      expBits = 8'hB6;
      doReset();
      doLoad(8'hB6, 4'd8);
      doStart(8'd0);
      for (int i = 0; i < 8; i++) begin
         assertCount++;
         if (w_valid !== 1'b1 || busy !== 1'b1 || w_out !== expBits[7-i] || bits_left !== 4'(8 - i)) begin
            failCount++;
            $display("[TB] FAIL single_bit%0d: got valid=%b busy=%b out=%b left=%0d, expected 1 1 %b %0d",
                     i, w_valid, busy, w_out, bits_left, expBits[7-i], 8 - i);
         end
         step();
      end
      assertCount++;
      if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL single_done: got done=%b busy=%b valid=%b, expected 1 0 0", done, busy, w_valid);
      end
      step();
      assertCount++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL single_ready: got done=%b busy=%b, expected 0 0", done, busy);
      end
   endtask

   task automatic test_divider();
      logic [3:0] expBits;
      logic       expValid;
      logic       expOut;
      logic [3:0] expLeft;
      expBits = 4'hD;
      doLoad(8'h0D, 4'd4);
      doStart(8'd2);
      for (int c = 1; c <= 12; c++) begin
         expValid = (c % 3 == 0);
         expOut   = expBits[3 - (c - 1) / 3];
         expLeft  = 4'(4 - (c - 1) / 3);
         assertCount++;
         if (w_valid !== expValid || w_out !== expOut || bits_left !== expLeft || busy !== 1'b1 || done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL divider_cycle%0d: got valid=%b out=%b left=%0d busy=%b done=%b, expected %b %b %0d 1 0",
                     c, w_valid, w_out, bits_left, busy, done, expValid, expOut, expLeft);
         end
         step();
      end
      assertCount++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL divider_done: got done=%b busy=%b, expected 1 0", done, busy);
      end
      step();
   endtask

   task automatic test_ignored();
      logic [3:0] expBits;
      expBits = 4'h5;
      doReset();
      doLoad(8'hFF, 4'd0);
      doStart(8'd0);
      assertCount++;
      if (busy !== 1'b0 || w_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL ignore_len0: got busy=%b valid=%b, expected 0 0", busy, w_valid);
      end
      doLoad(8'h0F, 4'd4);
      pattern = 8'h05;
      len     = 4'd4;
      load    = 1'b1;
      start   = 1'b1;
      step();
      load    = 1'b0;
      start   = 1'b0;
      assertCount++;
      if (busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL ignore_load_start: got busy=%b, expected 0", busy);
      end
      step();
      doStart(8'd0);
      for (int i = 0; i < 4; i++) begin
         assertCount++;
         if (w_valid !== 1'b1 || w_out !== expBits[3-i]) begin
            failCount++;
            $display("[TB] FAIL ignore_shift_bit%0d: got valid=%b out=%b, expected 1 %b", i, w_valid, w_out, expBits[3-i]);
         end
         if (i == 0) begin
            pattern = 8'hFF;
            len     = 4'd8;
            load    = 1'b1;
         end
         if (i == 2) begin
            load = 1'b0;
         end
         step();
      end
      assertCount++;
      if (done !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL ignore_done: got done=%b, expected 1", done);
      end
      step();
   endtask

   task automatic test_reset_mid_shift();
      doLoad(8'hB6, 4'd8);
      doStart(8'd1);
      for (int c = 1; c < 5; c++) begin
         step();
      end
      assertCount++;
      if (busy !== 1'b1 || bits_left !== 4'd6) begin
         failCount++;
         $display("[TB] FAIL midreset_pre: got busy=%b left=%0d, expected 1 6", busy, bits_left);
      end
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      assertCount++;
      if ({w_out, w_valid, busy, done, bits_left} !== 8'h00) begin
         failCount++;
         $display("[TB] FAIL midreset_outputs: got %b, expected 00000000", {w_out, w_valid, busy, done, bits_left});
      end
      for (int c = 0; c < 3; c++) begin
         step();
         assertCount++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midreset_quiet%0d: got done=%b busy=%b, expected 0 0", c, done, busy);
         end
      end
      doStart(8'd0);
      assertCount++;
      if (busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL midreset_start_ignored: got busy=%b, expected 0", busy);
      end
      step();
   endtask

   task automatic test_clamp_replay();
      logic [7:0] expBits;
      expBits = 8'hA5;
      doReset();
      doLoad(8'hA5, 4'd12);
      for (int pass = 0; pass < 2; pass++) begin
         doStart(8'd0);
         for (int i = 0; i < 8; i++) begin
            assertCount++;
            if (w_valid !== 1'b1 || w_out !== expBits[7-i] || bits_left !== 4'(8 - i)) begin
               failCount++;
               $display("[TB] FAIL clamp_pass%0d_bit%0d: got valid=%b out=%b left=%0d, expected 1 %b %0d",
                        pass, i, w_valid, w_out, bits_left, expBits[7-i], 8 - i);
            end
            step();
         end
         assertCount++;
         if (done !== 1'b1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL clamp_pass%0d_done: got done=%b busy=%b, expected 1 0", pass, done, busy);
         end
         step();
      end
   endtask

`ifdef SERIAL_SRC_REPEAT_EN
   task automatic test_repeat();
      logic [3:0] expBits;
      expBits = 4'hB;
      doReset();
      doLoad(8'h0B, 4'd4);
      repeat_mode = 1'b1;
      doStart(8'd0);
      for (int i = 0; i < 16; i++) begin
         assertCount++;
         if (w_valid !== 1'b1 || done !== 1'b0 || w_out !== expBits[3 - (i % 4)]) begin
            failCount++;
            $display("[TB] FAIL repeat_bit%0d: got valid=%b done=%b out=%b, expected 1 0 %b",
                     i, w_valid, done, w_out, expBits[3 - (i % 4)]);
         end
         if (i == 12) begin
            repeat_mode = 1'b0;
         end
         step();
      end
      assertCount++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL repeat_done: got done=%b busy=%b, expected 1 0", done, busy);
      end
      step();
   endtask
`endif

   initial begin
      assertCount = 0;
      failCount   = 0;
      resetn      = 1'b0;
      load        = 1'b0;
      pattern     = '0;
      len         = '0;
      rate        = '0;
      start       = 1'b0;
`ifdef SERIAL_SRC_REPEAT_EN
      repeat_mode = 1'b0;
`endif
      test_reset();
      test_single_shot();
      test_divider();
      test_ignored();
      test_reset_mid_shift();
      test_clamp_replay();
`ifdef SERIAL_SRC_REPEAT_EN
      test_repeat();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
